// File: rtl/sprite_anim_ctrl_if.sv
// sprite_anim_ctrl_if: timing inputs and sprite-engine outputs of sprite_anim_ctrl.
interface sprite_anim_ctrl_if #(
  parameter int CORDW = 12,
  parameter int ADDRW = 11,
  parameter int FRW = 2
);
  logic run;
  logic [CORDW-1:0] sx;
  logic [CORDW-1:0] sy;
  logic [CORDW-1:0] sprx;
  logic [CORDW-1:0] spry;
  logic [ADDRW-1:0] base_addr;
  logic [FRW-1:0] frame;
  logic spr_start;
  logic flip;
  logic tick;
  modport master(output run, sx, sy, input sprx, spry, base_addr, frame, spr_start, flip, tick);
  modport slave(input run, sx, sy, output sprx, spry, base_addr, frame, spr_start, flip, tick);
endinterface

// File: rtl/sprite_anim_ctrl.sv
// sprite_anim_ctrl: per-frame sprite position, walk-cycle frame and line-start pulse.
// Define SPRITE_ANIM_BOUNCE_EN for the LEFT/RIGHT bounce build; otherwise leftward wrap only.
module sprite_anim_ctrl #(
  parameter int CORDW = 12,
  parameter int ADDRW = 11,
  parameter int H_RES = 1920,
  parameter int V_RES = 1080,
  parameter int H_RES_FULL = 2200,
  parameter int V_RES_FULL = 1125,
  parameter int SPR_PIXELS = 640,
  parameter int FRAMES = 3,
  parameter int FRAME_TICKS = 16,
  parameter int SPEED_X = 6,
  parameter int SPR_W_S = 384,
  parameter int START_X = 0,
  parameter int START_Y = 420
) (
  input logic clk_pix,
  input logic rst_n,
  sprite_anim_ctrl_if.slave bus
);
  localparam int FRW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int HW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CORDW-1:0] SPD = CORDW'(SPEED_X);
  localparam logic [CORDW-1:0] X0 = CORDW'(START_X);
  localparam logic [CORDW-1:0] Y0 = CORDW'(START_Y);
  localparam logic [CORDW-1:0] Y_COR = CORDW'((START_Y == 0) ? V_RES_FULL - 1 : START_Y - 1);
  localparam logic [CORDW-1:0] X_LAST = CORDW'(H_RES - 1);
  localparam logic [CORDW-1:0] Y_ANIM = CORDW'(V_RES);
  localparam logic [ADDRW-1:0] SPR_STEP = ADDRW'(SPR_PIXELS);
  if (FRAMES < 1 || FRAME_TICKS < 1 || SPEED_X < 1 || SPEED_X >= H_RES_FULL || SPR_W_S > H_RES) begin : g_bad_params
    $error("sprite_anim_ctrl: illegal parameter set");
  end
  logic [CORDW-1:0] sprx, spry, sprx_nx;
  logic [ADDRW-1:0] base_addr;
  logic [FRW-1:0] frame;
  logic [HW-1:0] hold;
  logic spr_start, tick, flip, update;
  assign update = bus.run && bus.sy == Y_ANIM && bus.sx == '0;
`ifdef SPRITE_ANIM_BOUNCE_EN
  localparam logic [CORDW-1:0] X_MAX = CORDW'(H_RES - SPR_W_S);
  typedef enum logic {LEFT, RIGHT} dir_t;
  dir_t dir;
  logic [CORDW-1:0] sum;
  assign sum = sprx + SPD;
  always_comb sprx_nx = (dir == RIGHT) ? ((sum > X_MAX) ? X_MAX : sum) : ((sprx < SPD) ? '0 : sprx - SPD);
  always_ff @(posedge clk_pix or negedge rst_n)
    if (!rst_n) begin
      dir <= LEFT;
      flip <= 1'b0;
    end else if (update) begin
      dir <= (dir == RIGHT) ? ((sum > X_MAX) ? LEFT : RIGHT) : ((sprx < SPD) ? RIGHT : LEFT);
      flip <= (dir == RIGHT) ? !(sum > X_MAX) : (sprx < SPD);
    end
`else
  localparam logic [CORDW-1:0] WRAP = CORDW'(H_RES_FULL - SPEED_X);
  always_comb sprx_nx = (sprx >= SPD) ? sprx - SPD : sprx + WRAP;
  assign flip = 1'b0;
`endif
  always_ff @(posedge clk_pix or negedge rst_n)
    if (!rst_n) begin
      sprx <= X0;
      spry <= Y0;
      frame <= '0;
      base_addr <= '0;
      hold <= '0;
      spr_start <= 1'b0;
      tick <= 1'b0;
    end else begin
      spr_start <= bus.sy == Y_COR && bus.sx == X_LAST;
      tick <= update;
      if (update) begin
        sprx <= sprx_nx;
        hold <= (hold == HW'(FRAME_TICKS - 1)) ? '0 : hold + 1'b1;
        if (hold == HW'(FRAME_TICKS - 1)) begin
          frame <= (frame == FRW'(FRAMES - 1)) ? '0 : frame + 1'b1;
          base_addr <= (frame == FRW'(FRAMES - 1)) ? '0 : base_addr + SPR_STEP;
        end
      end
    end
  assign bus.sprx = sprx;
  assign bus.spry = spry;
  assign bus.base_addr = base_addr;
  assign bus.frame = frame;
  assign bus.spr_start = spr_start;
  assign bus.flip = flip;
  assign bus.tick = tick;
endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// tb_sprite_anim_ctrl: directed checks of sprite_anim_ctrl, default and START_Y=0/START_X=3 instances.
module tb_sprite_anim_ctrl;
  logic clk_pix = 1'b0;
  logic rst_n = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk_pix = ~clk_pix;
  sprite_anim_ctrl_if #(.CORDW(12), .ADDRW(11), .FRW(2)) b1 ();
  sprite_anim_ctrl_if #(.CORDW(12), .ADDRW(11), .FRW(2)) b2 ();
  sprite_anim_ctrl dut1 (.clk_pix(clk_pix), .rst_n(rst_n), .bus(b1));
  sprite_anim_ctrl #(.START_X(3), .START_Y(0)) dut2 (.clk_pix(clk_pix), .rst_n(rst_n), .bus(b2));
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int x, input int y);
    b1.sx = 12'(x);
    b1.sy = 12'(y);
    b2.sx = 12'(x);
    b2.sy = 12'(y);
    @(posedge clk_pix);
    #1;
  endtask
  task automatic adv();
    cyc(0, 1080);
    cyc(1, 1080);
  endtask
  task automatic set_run(input logic r);
    b1.run = r;
    b2.run = r;
  endtask
  initial begin
    set_run(1'b0);
    b1.sx = '0; b1.sy = '0; b2.sx = '0; b2.sy = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sprx", b1.sprx, 0);
    chk("rst_spry", b1.spry, 420);
    chk("rst_frame", b1.frame, 0);
    chk("rst_base", b1.base_addr, 0);
    chk("rst_tick", b1.tick, 0);
    chk("rst_start", b1.spr_start, 0);
    chk("rst_flip", b1.flip, 0);
    chk("rst_sprx2", b2.sprx, 3);
    chk("rst_spry2", b2.spry, 0);
    cyc(5, 5);
    rst_n = 1'b1;
    set_run(1'b1);
    cyc(0, 1080);
    chk("u1_tick", b1.tick, 1);
    chk("u1_sprx", b1.sprx, 2194);
    chk("u1_frame", b1.frame, 0);
`ifdef SPRITE_ANIM_BOUNCE_EN
    chk("u1_sprx2", b2.sprx, 0);
    chk("u1_flip2", b2.flip, 1);
`else
    chk("u1_sprx2", b2.sprx, 2197);
    chk("u1_flip2", b2.flip, 0);
`endif
    cyc(1, 1080);
    chk("u1_tick_end", b1.tick, 0);
    for (int n = 2; n <= 48; n++) begin
      adv();
      if (n == 15) chk("f15_frame", b1.frame, 0);
      if (n == 16) begin
        chk("f16_frame", b1.frame, 1);
        chk("f16_base", b1.base_addr, 640);
        chk("f16_sprx", b1.sprx, 2104);
      end
      if (n == 31) chk("f31_frame", b1.frame, 1);
      if (n == 32) begin
        chk("f32_frame", b1.frame, 2);
        chk("f32_base", b1.base_addr, 1280);
        chk("f32_sprx", b1.sprx, 2008);
      end
      if (n == 48) begin
        chk("f48_frame", b1.frame, 0);
        chk("f48_base", b1.base_addr, 0);
        chk("f48_sprx", b1.sprx, 1912);
      end
    end
    cyc(1918, 419);
    chk("st_early", b1.spr_start, 0);
    cyc(1919, 419);
    chk("st_pulse", b1.spr_start, 1);
    chk("st_pulse2_none", b2.spr_start, 0);
    cyc(1920, 419);
    chk("st_end", b1.spr_start, 0);
    cyc(1919, 418);
    chk("st_wrong_line", b1.spr_start, 0);
    cyc(1919, 1124);
    chk("st_y0_pulse2", b2.spr_start, 1);
    chk("st_y0_none1", b1.spr_start, 0);
    cyc(1920, 1124);
    chk("st_y0_end2", b2.spr_start, 0);
    set_run(1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1080);
      chk("frz_tick", b1.tick, 0);
      cyc(1, 1080);
      cyc(1919, 419);
      chk("frz_start", b1.spr_start, 1);
      cyc(1920, 419);
    end
    chk("frz_sprx", b1.sprx, 1912);
    chk("frz_frame", b1.frame, 0);
    chk("frz_base", b1.base_addr, 0);
    set_run(1'b1);
    cyc(0, 1080);
    chk("resume_tick", b1.tick, 1);
    chk("resume_sprx", b1.sprx, 1906);
    cyc(1, 1080);
    for (int n = 50; n <= 258; n++) begin
      adv();
`ifdef SPRITE_ANIM_BOUNCE_EN
      if (n == 257) begin
        chk("b257_sprx2", b2.sprx, 1536);
        chk("b257_flip2", b2.flip, 1);
      end
      if (n == 258) begin
        chk("b258_sprx2", b2.sprx, 1536);
        chk("b258_flip2", b2.flip, 0);
      end
`else
      if (n == 258) chk("w258_sprx2", b2.sprx, 655);
`endif
    end
    chk("u258_sprx", b1.sprx, 652);
    chk("u258_frame", b1.frame, 1);
    chk("u258_base", b1.base_addr, 640);
    cyc(1900, 419);
    rst_n = 1'b0;
    #1;
    chk("ar_sprx", b1.sprx, 0);
    chk("ar_frame", b1.frame, 0);
    chk("ar_base", b1.base_addr, 0);
    chk("ar_sprx2", b2.sprx, 3);
    chk("ar_flip2", b2.flip, 0);
    cyc(1919, 419);
    chk("ar_no_start", b1.spr_start, 0);
    rst_n = 1'b1;
    cyc(1920, 419);
    chk("ar_no_start_1920", b1.spr_start, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sprite_anim_ctrl.md
# sprite_anim_ctrl

Per-frame animation controller that sits directly upstream of the sprite engine in the 1080p pixel pipeline. Once per video frame it advances the sprite's horizontal position and walk-cycle frame. It drives the sprite ROM base address. It also issues the sprite engine's line-start pulse in the horizontal blanking of the line before the sprite's first drawn line.

## Interface
Parameters:
- CORDW, 12: screen coordinate width.
- ADDRW, 11: sprite ROM address width.
- H_RES, 1920: active width.
- V_RES, 1080: active height.
- H_RES_FULL, 2200: total line length.
- V_RES_FULL, 1125: total lines.
- SPR_PIXELS, 640: ROM words per animation frame.
- FRAMES, 3: animation frames in ROM (≥1).
- FRAME_TICKS, 16: video frames each animation frame is held (≥1).
- SPEED_X, 6: pixels moved per video frame (1..H_RES_FULL-1).
- SPR_W_S, 384: scaled on-screen sprite width (bounce limit only).
- START_X, 0: reset X position.
- START_Y, 420: Y position, fixed.

Ports:
- clk_pix  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  animation enable; low freezes motion and frame sequencing.
- sx  in  CORDW  current screen X from display timings.
- sy  in  CORDW  current screen Y from display timings.
- sprx  out  CORDW  sprite X position, registered.
- spry  out  CORDW  sprite Y position, registered, constant START_Y.
- base_addr  out  ADDRW  ROM base of current frame = frame × SPR_PIXELS, registered.
- frame  out  $clog2(FRAMES) (min 1)  current animation frame index.
- spr_start  out  1  one-cycle sprite line-start pulse.
- flip  out  1  sprite faces right (bounce build only; else 0).
- tick  out  1  one-cycle pulse marking an applied animation update.

## Operation
- Animate condition: anim = (sy == V_RES && sx == 0), once per video frame. Update = anim && run.
- On update:
  - hold counter increments.
  - At FRAME_TICKS-1 the hold counter clears and frame advances; FRAMES-1 wraps to 0.
  - base_addr is maintained by adding SPR_PIXELS, or clearing to 0 on wrap. No multiplier.
- Leftward motion: if sprx ≥ SPEED_X then sprx − SPEED_X, else sprx + H_RES_FULL − SPEED_X. All arithmetic is in CORDW bits; the result is always < H_RES_FULL.
- Direction state machine (bounce build): states LEFT and RIGHT, reset to LEFT.
  - RIGHT: sprx + SPEED_X; if the sum exceeds H_RES − SPR_W_S, clamp to H_RES − SPR_W_S and go to LEFT.
  - LEFT: if sprx < SPEED_X, clamp to 0 and go to RIGHT; otherwise subtract SPEED_X.
  - flip = (state == RIGHT).
- spr_start:
  - spry_cor = (spry == 0) ? V_RES_FULL−1 : spry−1.
  - Registered from (sy == spry_cor && sx == H_RES−1), so the pulse is high exactly while sx == H_RES on line spry_cor.
  - Generated regardless of run.
- tick = registered update.
- run low: hold counter, frame, base_addr, sprx and direction are held. Deasserting and reasserting run introduces no skipped or double steps.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - sprx = START_X, spry = START_Y
  - frame = 0, base_addr = 0, hold counter = 0
  - state LEFT, flip = 0, spr_start = 0, tick = 0
- Release of rst_n is synchronous to clk_pix; the first update can occur on the first anim after release.
- Update latency: the outputs and tick change on the clock edge ending the anim cycle, visible while sx == 1 on line V_RES.
- Outputs are stable for the rest of the frame. No output changes during active video.
- Reset mid-frame aborts any pending spr_start. No pulse is issued until the next qualifying line.
- anim and the spr_start condition never coincide, because they occur at different sx.

## Configuration
- SPRITE_ANIM_BOUNCE_EN:
  - Defined: the LEFT/RIGHT state machine is compiled in. The sprite bounces between X = 0 and H_RES − SPR_W_S, and flip follows direction.
  - Undefined: leftward wrap-around motion only, no direction state, flip tied to 0.

## Test plan
- Reset then wrap: reset with START_X = 0, run = 1; step one video frame -> sprx = 2194, tick high for one cycle at (sx = 1, sy = 1080).
- Frame sequencing: 48 video frames -> frame is 0 for frames 1–15, 1 from the 16th update, 2 from the 32nd, 0 from the 48th; base_addr correspondingly 0 / 640 / 1280 / 0.
- spr_start placement: spry = 420 -> a single pulse at sy = 419, sx = 1920 per frame. Parameter override START_Y = 0 -> pulse at sy = 1124, sx = 1920.
- run freeze: run = 0 for 5 frames -> sprx, frame and base_addr unchanged, tick never high, spr_start still pulses each frame. Re-enable -> the next update steps by exactly SPEED_X.
- Bounce (macro defined), START_X = 3: first update -> sprx = 0, flip = 1. Run until the sprite exceeds 1536 -> sprx = 1536 and flip = 0 on that update.
- Async reset mid-frame: rst_n low at sy = 419, sx = 1900 -> all outputs return to reset values with no clock edge, and there is no spr_start at sx = 1920.
